// File: rtl/slt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slt_pkg
//  Description : Shared constants for the signed less-than comparator slice.
//                Holds the default operand width used by the slt top level.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package slt_pkg;

  // Default operand width for the comparator; any width >= 2 is legal.
  localparam int unsigned SLT_DEFAULT_N = 32;

endpackage : slt_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full-adder cell; one link of the ripple chain
//                that forms a - b inside slt.
//  Ports       : a, b   - addend bits
//                c_in   - carry from the less significant cell
//                sum    - sum bit
//                c_out  - carry to the more significant cell
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic w_half;

  assign w_half = a ^ b;
  assign sum    = w_half ^ c_in;
  // Carry is generated by a&b, or propagated from c_in when exactly one input is set.
  assign c_out  = (a & b) | (c_in & w_half);

endmodule : full_adder
`default_nettype wire

// File: rtl/slt.sv
`default_nettype none
// ============================================================================
//  Module      : slt
//  Description : Signed less-than comparator. a - b is formed as a + ~b + 1
//                through a ripple of full_adder cells; the sign of the
//                difference, corrected by the overflow flag, gives a < b.
//                A registered copy of the result is kept in out_q.
//  Ports       : clk      - sole clock, rising edge
//                rst_n    - asynchronous active-low reset (clears out_q only)
//                a, b     - N-bit two's-complement operands
//                out      - combinational 1 when a < b (signed)
//                out_q    - out registered on every rising clk edge
//                overflow - combinational overflow of the subtraction a - b
//  Revision    : 1.0 - initial release
// ============================================================================
module slt
  import slt_pkg::*;
#(
  parameter int unsigned N = SLT_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out,
  output logic         out_q,
  output logic         overflow
);

  logic [N-1:0] w_b_inv;
  logic [N-1:0] w_diff;
  // w_carry[i] is the carry into bit i; w_carry[N] is the carry out of the MSB.
  logic [N:0]   w_carry;

  assign w_b_inv    = ~b;
  // Carry-in of 1 completes the two's-complement negation of b.
  assign w_carry[0] = 1'b1;

  for (genvar gi = 0; gi < N; gi++) begin : g_ripple
    full_adder u_fa (
      .a     (a[gi]),
      .b     (w_b_inv[gi]),
      .c_in  (w_carry[gi]),
      .sum   (w_diff[gi]),
      .c_out (w_carry[gi+1])
    );
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign overflow = w_carry[N-1] ^ w_carry[N];

  // When the subtraction wraps, the sign bit of the difference is inverted,
  // so flipping it by overflow recovers the true sign of a - b.
  assign out = w_diff[N-1] ^ overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out;
    end
  end

endmodule : slt
`default_nettype wire

// File: tb/tb_slt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slt
//  Description : Self-checking bench for slt. A behavioural model computes the
//                signed comparison and overflow from plain integer arithmetic;
//                a compare process checks every cycle, and directed cases pin
//                the boundary values with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slt;

  localparam int unsigned N = 32;
  localparam logic [N-1:0] C_MIN = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] C_MAX = {1'b0, {(N-1){1'b1}}};

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out;
  logic         out_q;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  logic exp_q;

  slt #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .out      (out),
    .out_q    (out_q),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic logic m_lt(input logic [N-1:0] x, input logic [N-1:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    return (sx < sy) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic m_ovf(input logic [N-1:0] x, input logic [N-1:0] y);
    longint d   = longint'($signed(x)) - longint'($signed(y));
    longint hi  = (longint'(1) <<< (N-1)) - 1;
    longint lo  = -(longint'(1) <<< (N-1));
    return ((d > hi) || (d < lo)) ? 1'b1 : 1'b0;
  endfunction

  // Expected registered result: cleared while reset is low, otherwise
  // captures the model's comparison on each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= 1'b0;
    else        exp_q <= m_lt(a, b);
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (a=%h b=%h t=%0t)", name, act, exp, a, b, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    check("cyc_out", out, m_lt(a, b));
    check("cyc_ovf", overflow, m_ovf(a, b));
    check("cyc_out_q", out_q, exp_q);
  end

  task automatic directed(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic e_out, input logic e_ovf);
    @(posedge clk);
    #3;
    a = x;
    b = y;
    #1;
    check({name, "_out"}, out, e_out);
    check({name, "_ovf"}, overflow, e_ovf);
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] v;
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = C_MIN;
      2: v = C_MAX;
      3: v = '1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    rst_n = 1'b1;
    a = -32'sd5;
    b = 32'sd3;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out_q", out_q, 1'b0);
    // Reset must not disturb the combinational outputs.
    check("rst_out", out, 1'b1);
    check("rst_ovf", overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_out_q", out_q, 1'b0);

    // Release reset mid-cycle with a=-5, b=3; one rising edge loads 1.
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_out_q", out_q, 1'b1);
    // Mid-cycle reset assertion clears out_q immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_q", out_q, 1'b0);
    #1;
    rst_n = 1'b1;

    directed("zero_zero",   '0,    '0,    1'b0, 1'b0);
    directed("m1_p1",       '1,    32'd1, 1'b1, 1'b0);
    directed("max_min",     C_MAX, C_MIN, 1'b0, 1'b1);
    directed("min_max",     C_MIN, C_MAX, 1'b1, 1'b1);
    directed("min_min",     C_MIN, C_MIN, 1'b0, 1'b0);
    directed("max_max",     C_MAX, C_MAX, 1'b0, 1'b0);
    directed("p3_m5",       32'd3, -32'sd5, 1'b0, 1'b0);
    directed("min_p1",      C_MIN, 32'd1, 1'b1, 1'b1);
    directed("m1_min",      '1,    C_MIN, 1'b0, 1'b0);

    // Randomised pairs, biased toward the signed extremes and equal operands.
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #3;
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? a : pick();
      if (i == 60) rst_n = 1'b0;
      if (i == 62) rst_n = 1'b1;
      #1;
      check("rnd_out", out, m_lt(a, b));
      check("rnd_ovf", overflow, m_ovf(a, b));
      if (i == 60) check("rnd_rst_out_q", out_q, 1'b0);
    end

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_slt
`default_nettype wire
